// File: rtl/mix_tree_sequencer.sv
// Job sequencer for a binary mixer tree: load inlets, then mix/transfer
// level by level from leaves to root, then flush the outlet path.
module mix_tree_sequencer #(
    parameter int DEPTH        = 6,
    parameter int LOAD_CYCLES  = 16,
    parameter int MIX_CYCLES   = 64,
    parameter int XFER_CYCLES  = 8,
    parameter int FLUSH_CYCLES = 8,
    parameter int TW           = 16,
    localparam int N_IN        = 2**DEPTH,
    localparam int N_MIX       = N_IN - 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [N_IN-1:0]  inlet_mask,
    input  logic             abort,
    output logic [N_IN-1:0]  inlet_valve_o,
    output logic [N_MIX-1:0] mix_en_o,
    output logic [DEPTH-1:0] xfer_o,
    output logic             flush_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);

    localparam int LW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [TW-1:0] LOAD_LAST  = TW'(LOAD_CYCLES - 1);
    localparam logic [TW-1:0] MIX_LAST   = TW'(MIX_CYCLES - 1);
    localparam logic [TW-1:0] XFER_LAST  = TW'(XFER_CYCLES - 1);
    localparam logic [TW-1:0] FLUSH_LAST = TW'(FLUSH_CYCLES - 1);
    localparam logic [LW-1:0] LVL_TOP    = LW'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_MIX, S_XFER, S_FLUSH
    } state_t;

    state_t          state_q, state_n;
    logic [LW-1:0]   lvl_q, lvl_n;
    logic [TW-1:0]   tmr_q, tmr_n;
    logic [N_IN-1:0] mask_q, mask_n;
    logic            abt_q, abt_n;
    logic            done_n, err_n;

    logic [N_MIX-1:0] lvl_or, lvl_hit;

    // Per-mixer occupancy: a mixer runs only if its subtree holds a selected inlet
    for (genvar l = 0; l < DEPTH; l++) begin : g_lvl
        localparam int OFF = N_IN - (N_IN >> l);
        localparam int CNT = N_IN >> (l + 1);
        localparam int W   = 2**(l + 1);
        for (genvar j = 0; j < CNT; j++) begin : g_mix
            assign lvl_or[OFF+j]  = |mask_n[j*W +: W];
            assign lvl_hit[OFF+j] = (lvl_n == LW'(l));
        end
    end

    always_comb begin
        state_n = state_q;
        lvl_n   = lvl_q;
        tmr_n   = tmr_q;
        mask_n  = mask_q;
        abt_n   = abt_q;
        done_n  = 1'b0;
        err_n   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_valid) begin
                    if (|inlet_mask) begin
                        state_n = S_LOAD;
                        mask_n  = inlet_mask;
                        lvl_n   = '0;
                        tmr_n   = '0;
                        abt_n   = 1'b0;
                    end else begin
                        done_n = 1'b1;
                        err_n  = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                tmr_n = tmr_q + TW'(1);
                if (tmr_q == LOAD_LAST) begin
                    state_n = S_MIX;
                    tmr_n   = '0;
                end
            end
            S_MIX: begin
                tmr_n = tmr_q + TW'(1);
                if (tmr_q == MIX_LAST) begin
                    state_n = S_XFER;
                    tmr_n   = '0;
                end
            end
            S_XFER: begin
                tmr_n = tmr_q + TW'(1);
                if (tmr_q == XFER_LAST) begin
                    tmr_n = '0;
                    if (lvl_q == LVL_TOP) begin
                        state_n = S_FLUSH;
                    end else begin
                        state_n = S_MIX;
                        lvl_n   = lvl_q + LW'(1);
                    end
                end
            end
            S_FLUSH: begin
                tmr_n = tmr_q + TW'(1);
                if (tmr_q == FLUSH_LAST) begin
                    state_n = S_IDLE;
                    tmr_n   = '0;
                    done_n  = 1'b1;
                    err_n   = abt_q;
                end
            end
            default: state_n = S_IDLE;
        endcase
        // Abort overrides any phase-end transition taken above
        if (abort && (state_q == S_LOAD || state_q == S_MIX ||
                      state_q == S_XFER)) begin
            state_n = S_FLUSH;
            tmr_n   = '0;
            abt_n   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            lvl_q         <= '0;
            tmr_q         <= '0;
            mask_q        <= '0;
            abt_q         <= 1'b0;
            start_ready   <= 1'b1;
            inlet_valve_o <= '0;
            mix_en_o      <= '0;
            xfer_o        <= '0;
            flush_o       <= 1'b0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            err_o         <= 1'b0;
        end else begin
            state_q       <= state_n;
            lvl_q         <= lvl_n;
            tmr_q         <= tmr_n;
            mask_q        <= mask_n;
            abt_q         <= abt_n;
            start_ready   <= (state_n == S_IDLE);
            inlet_valve_o <= (state_n == S_LOAD) ? mask_n : '0;
            mix_en_o      <= (state_n == S_MIX) ? (lvl_or & lvl_hit) : '0;
            xfer_o        <= (state_n == S_XFER) ? (DEPTH'(1) << lvl_n)
                                                 : {DEPTH{state_n == S_FLUSH}};
            flush_o       <= (state_n == S_FLUSH);
            busy_o        <= (state_n != S_IDLE);
            done_o        <= done_n;
            err_o         <= err_n;
        end
    end

endmodule

// File: tb/tb_mix_tree_sequencer.sv
// Bench for mix_tree_sequencer: job-position model compared every cycle,
// plus directed scenarios with hand-computed totals.
module tb_mix_tree_sequencer;

    localparam int DEPTH = 6;
    localparam int LC    = 2;
    localparam int MC    = 3;
    localparam int XC    = 2;
    localparam int FC    = 2;
    localparam int NIN   = 64;
    localparam int NMIX  = 63;
    localparam int TOT   = LC + DEPTH*(MC+XC) + FC;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            start_valid = 1'b0;
    logic            start_ready;
    logic [NIN-1:0]  inlet_mask = '0;
    logic            abort = 1'b0;
    logic [NIN-1:0]  inlet_valve_o;
    logic [NMIX-1:0] mix_en_o;
    logic [DEPTH-1:0] xfer_o;
    logic            flush_o, busy_o, done_o, err_o;

    always #5 clk = ~clk;

    mix_tree_sequencer #(
        .DEPTH(DEPTH), .LOAD_CYCLES(LC), .MIX_CYCLES(MC),
        .XFER_CYCLES(XC), .FLUSH_CYCLES(FC), .TW(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .start_valid(start_valid), .start_ready(start_ready),
        .inlet_mask(inlet_mask), .abort(abort),
        .inlet_valve_o(inlet_valve_o), .mix_en_o(mix_en_o),
        .xfer_o(xfer_o), .flush_o(flush_o), .busy_o(busy_o),
        .done_o(done_o), .err_o(err_o)
    );

    int checks = 0;
    int errors = 0;
    bit go = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    // Model: position within the job timeline (-1 = none), abort-flush position
    int          ph_k = -1;
    int          abt_k = -1;
    logic [63:0] m_mask = '0;
    bit          m_done = 1'b0;
    bit          m_err = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph_k <= -1; abt_k <= -1; m_mask <= '0;
            m_done <= 1'b0; m_err <= 1'b0;
        end else begin
            m_done <= 1'b0;
            m_err  <= 1'b0;
            if (ph_k < 0 && abt_k < 0) begin
                if (start_valid) begin
                    if (inlet_mask != 0) begin
                        ph_k <= 0; m_mask <= inlet_mask;
                    end else begin
                        m_done <= 1'b1; m_err <= 1'b1;
                    end
                end
            end else if (abt_k >= 0) begin
                if (abt_k == FC-1) begin
                    abt_k <= -1; m_done <= 1'b1; m_err <= 1'b1;
                end else abt_k <= abt_k + 1;
            end else if (abort && ph_k < TOT-FC) begin
                ph_k <= -1; abt_k <= 0;
            end else if (ph_k == TOT-1) begin
                ph_k <= -1; m_done <= 1'b1;
            end else ph_k <= ph_k + 1;
        end
    end

    function automatic logic [62:0] e_mix(int k, logic [63:0] m);
        logic [62:0] v;
        int r, l, off, cnt, w;
        v = '0;
        if (k >= LC && k < TOT-FC) begin
            r = k - LC;
            l = r / (MC+XC);
            if (r % (MC+XC) < MC) begin
                off = NIN - (NIN >> l);
                cnt = NIN >> (l+1);
                w   = NIN / cnt;
                for (int j = 0; j < cnt; j++)
                    for (int b = 0; b < w; b++)
                        if (m[j*w+b]) v[off+j] = 1'b1;
            end
        end
        return v;
    endfunction

    function automatic logic [5:0] e_xfer(int k, int a);
        int r;
        if (a >= 0 || k >= TOT-FC) return 6'h3F;
        if (k >= LC) begin
            r = k - LC;
            if (r % (MC+XC) >= MC) return 6'(1 << (r / (MC+XC)));
        end
        return 6'h0;
    endfunction

    always @(negedge clk) begin
        if (go) begin
            chk("busy", busy_o, (ph_k >= 0 || abt_k >= 0));
            chk("ready", start_ready, !(ph_k >= 0 || abt_k >= 0));
            chk("inlet", inlet_valve_o,
                (ph_k >= 0 && ph_k < LC) ? m_mask : 64'h0);
            chk("mix", mix_en_o, e_mix(ph_k, m_mask));
            chk("xfer", xfer_o, e_xfer(ph_k, abt_k));
            chk("flush", flush_o, (abt_k >= 0 || ph_k >= TOT-FC));
            chk("done", done_o, m_done);
            chk("err", err_o, m_err);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int nb, output int nf, output int ni,
                             output logic [62:0] ma, output logic [5:0] xa,
                             output bit e);
        nb = 0; nf = 0; ni = 0; ma = '0; xa = '0; e = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done_o) begin
                e = err_o;
                return;
            end
            nb += int'(busy_o);
            nf += int'(flush_o);
            ni += int'(inlet_valve_o != 0);
            ma |= mix_en_o;
            if (!flush_o) xa |= xfer_o;
        end
        checks++;
        errors++;
        $display("FAIL done_timeout got none want done_o within 200 cycles");
    endtask

    initial begin
        int nb, nf, ni, nd;
        logic [62:0] ma;
        logic [5:0] xa;
        bit e;

        #1 rst_n = 1'b0;
        go = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ready", start_ready, 1);
        chk("rst_busy", busy_o, 0);
        rst_n = 1'b1;

        // T1 full job
        tick(1); start_valid = 1'b1; inlet_mask = '1;
        tick(1); start_valid = 1'b0; inlet_mask = '0;
        wait_done(nb, nf, ni, ma, xa, e);
        chk("t1_busy", nb, 34);
        chk("t1_flush", nf, 2);
        chk("t1_inlet", ni, 2);
        chk("t1_mix", ma, 63'h7FFF_FFFF_FFFF_FFFF);
        chk("t1_xfer", xa, 6'h3F);
        chk("t1_err", e, 0);

        // T2 sparse job
        tick(1); start_valid = 1'b1; inlet_mask = 64'h1;
        tick(1); start_valid = 1'b0;
        wait_done(nb, nf, ni, ma, xa, e);
        chk("t2_busy", nb, 34);
        chk("t2_inlet", ni, 2);
        chk("t2_mix", ma, 63'h5101_0001_0000_0001);

        // T3 abort in second cycle of level-2 MIX
        tick(1); start_valid = 1'b1; inlet_mask = 64'hFF00;
        tick(1); start_valid = 1'b0;
        tick(13); abort = 1'b1;
        tick(1); abort = 1'b0;
        wait_done(nb, nf, ni, ma, xa, e);
        chk("t3_busy", nb, 2);
        chk("t3_flush", nf, 2);
        chk("t3_err", e, 1);

        // T4 empty job, then start held while busy
        tick(1); start_valid = 1'b1; inlet_mask = '0;
        tick(1); start_valid = 1'b0;
        @(negedge clk);
        chk("t4_done", done_o, 1);
        chk("t4_err", err_o, 1);
        chk("t4_busy", busy_o, 0);
        tick(1); start_valid = 1'b1; inlet_mask = 64'h3;
        nd = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            nd += int'(done_o);
        end
        start_valid = 1'b0;
        wait_done(nb, nf, ni, ma, xa, e);
        nd += 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            nd += int'(done_o);
        end
        chk("t4_one_done", nd, 1);

        // T5 reset during level-0 XFER
        tick(1); start_valid = 1'b1; inlet_mask = '1;
        tick(1); start_valid = 1'b0;
        tick(5);
        chk("t5_pre_xfer", xfer_o, 6'h01);
        rst_n = 1'b0;
        #1;
        chk("t5_xfer", xfer_o, 0);
        chk("t5_mix", mix_en_o, 0);
        chk("t5_inlet", inlet_valve_o, 0);
        chk("t5_flush", flush_o, 0);
        chk("t5_ready", start_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // back-to-back: start offered in the done cycle
        tick(1); start_valid = 1'b1; inlet_mask = 64'h5;
        tick(1); start_valid = 1'b0;
        wait_done(nb, nf, ni, ma, xa, e);
        start_valid = 1'b1; inlet_mask = 64'h7;
        @(posedge clk); #1;
        start_valid = 1'b0; inlet_mask = '0;
        @(negedge clk);
        chk("b2b_busy0", busy_o, 1);
        chk("b2b_inlet", inlet_valve_o, 64'h7);
        wait_done(nb, nf, ni, ma, xa, e);
        chk("b2b_busy", nb, 33);
        chk("b2b_err", e, 0);

        tick(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
